// File: rtl/vga_scaled_fb_reader.sv
// -----------------------------------------------------------------------------
// vga_scaled_fb_reader
//
// VGA timing generator plus framebuffer reader. A clock divider produces a
// pixel tick. Horizontal and vertical counters step on that tick. A two-stage
// pipeline turns the counter position into a BRAM read (stage A) and into
// pixel data aligned with sync and display enable (stage B).
//
// The IMG_W x IMG_H image sits at the top-left of the active area. Each image
// pixel is replicated SCALE times in x and in y. Active pixels outside the
// image show BORDER_COLOR.
//
// Ports
//   clk          system clock
//   reset        synchronous reset, active-high
//   bram_addr    byte read address (holds its last value outside the image)
//   bram_en      read enable, high while the addressed pixel is in the image
//   bram_rdata   read data, valid BRAM_LAT clk cycles after the address
//   hsync/vsync  registered sync outputs, asserted level = SYNC_POL
//   de           display enable (active video)
//   pixel        pixel value, 0 whenever de is low
//   frame_start  one-clk pulse while the (0,0) pixel is presented
// -----------------------------------------------------------------------------
module vga_scaled_fb_reader #(
  parameter int unsigned       CLK_DIV      = 4,
  parameter int unsigned       H_ACTIVE     = 640,
  parameter int unsigned       H_FP         = 16,
  parameter int unsigned       H_SYNC       = 96,
  parameter int unsigned       H_BP         = 48,
  parameter int unsigned       V_ACTIVE     = 480,
  parameter int unsigned       V_FP         = 10,
  parameter int unsigned       V_SYNC       = 2,
  parameter int unsigned       V_BP         = 33,
  parameter bit                SYNC_POL     = 1'b0,
  parameter int unsigned       IMG_W        = 256,
  parameter int unsigned       IMG_H        = 144,
  parameter int unsigned       SCALE        = 1,
  parameter logic [31:0]       BASE_ADDR    = 32'h0,
  parameter int unsigned       ADDR_STRIDE  = 2,
  parameter int unsigned       PIX_W        = 16,
  parameter int unsigned       BRAM_LAT     = 1,
  parameter logic [PIX_W-1:0]  BORDER_COLOR = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      bram_addr,
  output logic             bram_en,
  input  logic [PIX_W-1:0] bram_rdata,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [PIX_W-1:0] pixel,
  output logic             frame_start
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (CLK_DIV < 2 || CLK_DIV <= BRAM_LAT) begin : g_bad_div
    $error("CLK_DIV must be >= 2 and exceed BRAM_LAT");
  end
  if (SCALE < 1 || SCALE > 8) begin : g_bad_scale
    $error("SCALE must be in 1..8");
  end
  if (IMG_W * SCALE > H_ACTIVE || IMG_H * SCALE > V_ACTIVE) begin : g_bad_img
    $error("scaled image does not fit in the active area");
  end

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int          DW    = $clog2(CLK_DIV);
  localparam int          HW    = $clog2(H_TOT);
  localparam int          VW    = $clog2(V_TOT);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_IMG    = HW'(IMG_W * SCALE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_IMG    = VW'(IMG_H * SCALE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [3:0]    SUB_LAST = 4'(SCALE - 1);
  localparam logic [31:0]   PIX_STEP = 32'(ADDR_STRIDE);
  localparam logic [31:0]   ROW_STEP = 32'(IMG_W * ADDR_STRIDE);

  // ---------------------------------------------------------------------------
  // Divider, raster counters and address subcounters
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [3:0]    x_sub_q, x_sub_d;     // replication phase within an image column
  logic [31:0]   x_off_q, x_off_d;     // byte offset of the current column in a row
  logic [3:0]    y_sub_q, y_sub_d;     // replication phase within an image row
  logic [31:0]   row_base_q, row_base_d; // byte offset of the current image row
  logic          tick;

  assign tick = (div_q == DIV_LAST);

  // Address offsets advance incrementally, so no divide or multiply sits in
  // the per-pixel path: a column step happens every SCALE ticks and a row
  // step every SCALE lines.
  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    div_d      = div_q + 1'b1;
    h_d        = h_q;
    v_d        = v_q;
    x_sub_d    = x_sub_q;
    x_off_d    = x_off_q;
    y_sub_d    = y_sub_q;
    row_base_d = row_base_q;
    if (tick) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d     = '0;
        x_sub_d = '0;
        x_off_d = '0;
        if (v_q == V_LAST) begin
          v_d        = '0;
          y_sub_d    = '0;
          row_base_d = '0;
        end else begin
          v_d = v_q + 1'b1;
          if (y_sub_q == SUB_LAST) begin
            y_sub_d    = '0;
            row_base_d = row_base_q + ROW_STEP;
          end else begin
            y_sub_d = y_sub_q + 1'b1;
          end
        end
      end else begin
        h_d = h_q + 1'b1;
        if (x_sub_q == SUB_LAST) begin
          x_sub_d = '0;
          x_off_d = x_off_q + PIX_STEP;
        end else begin
          x_sub_d = x_sub_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage A (address/flags) and stage B (aligned outputs)
  // ---------------------------------------------------------------------------
  logic             hs_a_q, hs_a_d;
  logic             vs_a_q, vs_a_d;
  logic             act_a_q, act_a_d;
  logic             win_a_q, win_a_d;
  logic             first_a_q, first_a_d;   // stage A holds the (0,0) pixel
  logic [31:0]      addr_a_q, addr_a_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic             frame_start_q, frame_start_d;

  always_comb begin
    hs_a_d    = hs_a_q;
    vs_a_d    = vs_a_q;
    act_a_d   = act_a_q;
    win_a_d   = win_a_q;
    first_a_d = first_a_q;
    addr_a_d  = addr_a_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    de_d      = de_q;
    pixel_d   = pixel_q;
    // Pulses only in the clk right after the tick that loads (0,0) into B.
    frame_start_d = tick & first_a_q;
    if (tick) begin
      hs_a_d    = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
      vs_a_d    = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
      act_a_d   = (h_q < H_ACT) && (v_q < V_ACT);
      win_a_d   = (h_q < H_IMG) && (v_q < V_IMG);
      first_a_d = (h_q == '0) && (v_q == '0);
      if ((h_q < H_IMG) && (v_q < V_IMG)) begin
        addr_a_d = BASE_ADDR + row_base_q + x_off_q;
      end

      // bram_rdata is sampled a full pixel period after the address was
      // issued; CLK_DIV > BRAM_LAT guarantees the read has completed.
      hsync_d = hs_a_q ? SYNC_POL : ~SYNC_POL;
      vsync_d = vs_a_q ? SYNC_POL : ~SYNC_POL;
      de_d    = act_a_q;
      if (win_a_q) begin
        pixel_d = bram_rdata;
      end else if (act_a_q) begin
        pixel_d = BORDER_COLOR;
      end else begin
        pixel_d = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      x_sub_q       <= '0;
      x_off_q       <= '0;
      y_sub_q       <= '0;
      row_base_q    <= '0;
      hs_a_q        <= 1'b0;
      vs_a_q        <= 1'b0;
      act_a_q       <= 1'b0;
      win_a_q       <= 1'b0;
      first_a_q     <= 1'b0;
      addr_a_q      <= BASE_ADDR;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      pixel_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      x_sub_q       <= x_sub_d;
      x_off_q       <= x_off_d;
      y_sub_q       <= y_sub_d;
      row_base_q    <= row_base_d;
      hs_a_q        <= hs_a_d;
      vs_a_q        <= vs_a_d;
      act_a_q       <= act_a_d;
      win_a_q       <= win_a_d;
      first_a_q     <= first_a_d;
      addr_a_q      <= addr_a_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pixel_q       <= pixel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bram_addr   = addr_a_q;
  assign bram_en     = win_a_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pixel       = pixel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scaled_fb_reader.sv
// -----------------------------------------------------------------------------
// Testbench for vga_scaled_fb_reader.
//
// Three configurations run side by side from one clock and one reset:
//   g0: small raster, 4x2 image scaled x2, BASE 0x100, border 0xF800
//   g1: small raster, 5x3 image, SYNC_POL=1, stride 4, BRAM_LAT=2, CLK_DIV=3
//   g2: default parameters (first few lines only)
// A reference model computes the expected outputs for every counter position
// when the bench's own tick occurs; the entry is queued and popped two ticks
// later, when the DUT presents that pixel. Stage-A outputs (bram_en/addr) are
// compared against the most recently modelled position.
// -----------------------------------------------------------------------------
module tb_vga_scaled_fb_reader;

  typedef struct {
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        en;
    logic [31:0] addr;
    logic [15:0] pix;
    int          h;
    int          v;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;       // clk edges since the last edge that saw reset high
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int          CD   = (g == 0) ? 4 : (g == 1) ? 3 : 4;
    localparam int          HA   = (g == 0) ? 16 : (g == 1) ? 12 : 640;
    localparam int          HF   = (g == 0) ? 2 : (g == 1) ? 1 : 16;
    localparam int          HS   = (g == 0) ? 3 : (g == 1) ? 2 : 96;
    localparam int          HB   = (g == 0) ? 3 : (g == 1) ? 2 : 48;
    localparam int          VA   = (g == 0) ? 8 : (g == 1) ? 6 : 480;
    localparam int          VF   = (g == 0) ? 1 : (g == 1) ? 1 : 10;
    localparam int          VS   = (g == 0) ? 2 : (g == 1) ? 1 : 2;
    localparam int          VB   = (g == 0) ? 1 : (g == 1) ? 2 : 33;
    localparam bit          POL  = (g == 1);
    localparam int          IW   = (g == 0) ? 4 : (g == 1) ? 5 : 256;
    localparam int          IH   = (g == 0) ? 2 : (g == 1) ? 3 : 144;
    localparam int          SC   = (g == 0) ? 2 : 1;
    localparam logic [31:0] BASE = (g == 0) ? 32'h100 : (g == 1) ? 32'h2000 : 32'h0;
    localparam int          ST   = (g == 1) ? 4 : 2;
    localparam int          LAT  = (g == 1) ? 2 : 1;
    localparam logic [15:0] BORD = (g == 0) ? 16'hF800 : (g == 1) ? 16'h1234 : 16'h0;
    localparam int          HT   = HA + HF + HS + HB;
    localparam int          VT   = VA + VF + VS + VB;

    logic [31:0] bram_addr;
    logic        bram_en;
    logic [15:0] bram_rdata;
    logic        hsync, vsync, de, frame_start;
    logic [15:0] pixel;
    logic [15:0] pipe [0:3];

    // BRAM model: returns addr[15:0] LAT clks after the address, 0xDEAD when
    // the read was not enabled.
    always @(posedge clk) begin
      pipe[0] <= bram_en ? bram_addr[15:0] : 16'hDEAD;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_rdata = pipe[LAT-1];

    vga_scaled_fb_reader #(
      .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL),
      .IMG_W(IW), .IMG_H(IH), .SCALE(SC), .BASE_ADDR(BASE), .ADDR_STRIDE(ST),
      .PIX_W(16), .BRAM_LAT(LAT), .BORDER_COLOR(BORD)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .bram_addr  (bram_addr),
      .bram_en    (bram_en),
      .bram_rdata (bram_rdata),
      .hsync      (hsync),
      .vsync      (vsync),
      .de         (de),
      .pixel      (pixel),
      .frame_start(frame_start)
    );

    function automatic exp_t idle();
      exp_t e;
      e.hsync = ~POL;
      e.vsync = ~POL;
      e.de    = 1'b0;
      e.en    = 1'b0;
      e.addr  = BASE;
      e.pix   = 16'h0;
      e.h     = -1;
      e.v     = -1;
      return e;
    endfunction

    // Expected outputs for the i-th pixel tick since reset.
    function automatic exp_t model(input int i, input logic [31:0] prev_addr);
      exp_t e;
      int   h, v;
      logic act, win;
      h = i % HT;
      v = (i / HT) % VT;
      act = (h < HA) && (v < VA);
      win = (h < IW * SC) && (v < IH * SC);
      e.h     = h;
      e.v     = v;
      e.hsync = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
      e.vsync = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
      e.de    = act;
      e.en    = win;
      e.addr  = win ? BASE + 32'(((v / SC) * IW + h / SC) * ST) : prev_addr;
      e.pix   = win ? e.addr[15:0] : (act ? BORD : 16'h0);
      return e;
    endfunction

    exp_t q[$];
    exp_t cur_a, cur_b, pushed;

    always @(negedge clk) begin
      int    n, t;
      string pfx;
      n = cyc;
      t = n / CD;
      pfx = $sformatf("g%0d n=%0d", g, n);
      if (n == 0) begin
        q.delete();
        pushed = idle();
        cur_a  = idle();
        cur_b  = idle();
      end
      if (n % CD == 0 && t >= 1) cur_a = pushed;
      if (n % CD == 0 && t >= 2) begin
        if (q.size() > 0) cur_b = q.pop_front();
      end

      check({pfx, " bram_en"},   {31'd0, bram_en}, {31'd0, cur_a.en});
      check({pfx, " bram_addr"}, bram_addr, cur_a.addr);
      check({pfx, " hsync"},     {31'd0, hsync}, {31'd0, cur_b.hsync});
      check({pfx, " vsync"},     {31'd0, vsync}, {31'd0, cur_b.vsync});
      check({pfx, " de"},        {31'd0, de}, {31'd0, cur_b.de});
      check({pfx, " pixel"},     {16'd0, pixel}, {16'd0, cur_b.pix});
      check({pfx, " frame_start"}, {31'd0, frame_start},
            {31'd0, (n % CD == 0) && (cur_b.h == 0) && (cur_b.v == 0)});

      if (n % CD == CD - 1) begin
        pushed = model(t, pushed.addr);
        q.push_back(pushed);
      end
    end
  end

  initial begin
    repeat (10) @(negedge clk);
    #1 reset = 1'b0;
    repeat (4800) @(negedge clk);
    // One-clk reset in mid-frame: everything must restart from (0,0).
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (5000) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
